// File: rtl/dma_bus_master_if.sv
// Control/handshake bundle for the DMA bus master: transfer command,
// status, and the arbitrator request/grant plus slave access-complete.
interface dma_bus_master_if #(
    parameter int unsigned COUNT_W = 16
) ();
    logic               start;
    logic [31:0]        src_addr;
    logic [31:0]        dst_addr;
    logic [COUNT_W-1:0] word_count;
    logic               busy;
    logic               done;
    logic               dma_req;
    logic               dma_grant;
    logic               fc_bus;

    modport master (
        input  start, src_addr, dst_addr, word_count, dma_grant, fc_bus,
        output busy, done, dma_req
    );

    modport slave (
        output start, src_addr, dst_addr, word_count, dma_grant, fc_bus,
        input  busy, done, dma_req
    );
endinterface

// File: rtl/dma_bus_master.sv
// Single-channel memory-to-memory DMA bus master.
// Copies word_count 32-bit words from src_addr to dst_addr, one read then
// one write per word, owning the shared tri-state bus only while granted.
// Optional feature macro DMA_BURST_EN: when defined the bus is held for the
// whole transfer; when undefined the bus is released after every word.
module dma_bus_master #(
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    dma_bus_master_if.master        ctl,
    inout  wire  [31:0]             addr_bus,
    inout  wire  [31:0]             data_bus,
    inout  wire                     wr_bus,
    inout  wire                     rd_bus,
    inout  wire  [3:0]              data_mask_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_RD_END,
        S_WRITE,
        S_WR_END,
        S_DONE
    } state_t;

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_t             r_state;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [31:0]        r_addr;
    logic [31:0]        r_buf;
    logic [COUNT_W-1:0] r_rem;
    logic               r_dma_req;
    logic               r_busy;
    logic               r_done;
    logic               r_drv;
    logic               r_drv_data;
    logic               r_rd;
    logic               r_wr;

    logic               w_drv;
    logic               w_drv_data;

    // Transfer sequencer: state plus every bus/status output registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_addr     <= '0;
            r_buf      <= '0;
            r_rem      <= '0;
            r_dma_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_drv      <= 1'b0;
            r_drv_data <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctl.start) begin
                        r_busy <= 1'b1;
                        if (ctl.word_count != '0) begin
                            r_src     <= ctl.src_addr;
                            r_dst     <= ctl.dst_addr;
                            r_rem     <= ctl.word_count;
                            r_dma_req <= 1'b1;
                            r_state   <= S_REQ;
                        end else begin
                            // Empty transfer: report completion without touching the bus.
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (ctl.dma_grant) begin
                        r_drv      <= 1'b1;
                        r_drv_data <= 1'b0;
                        r_addr     <= r_src;
                        r_rd       <= 1'b1;
                        r_wr       <= 1'b0;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (ctl.fc_bus) begin
                        r_buf   <= data_bus;
                        r_rd    <= 1'b0;
                        r_state <= S_RD_END;
                    end
                end
                S_RD_END: begin
                    // Address/data switch while both strobes are low.
                    r_addr     <= r_dst;
                    r_drv_data <= 1'b1;
                    r_wr       <= 1'b1;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (ctl.fc_bus) begin
                        r_wr    <= 1'b0;
                        r_state <= S_WR_END;
`ifndef DMA_BURST_EN
                        // Give the bus back after every word so the CPU can win arbitration.
                        r_dma_req  <= 1'b0;
                        r_drv      <= 1'b0;
                        r_drv_data <= 1'b0;
`endif
                    end
                end
                S_WR_END: begin
                    r_src <= r_src + STEP;
                    r_dst <= r_dst + STEP;
                    r_rem <= r_rem - COUNT_W'(1);
                    if (r_rem == COUNT_W'(1)) begin
                        r_dma_req  <= 1'b0;
                        r_drv      <= 1'b0;
                        r_drv_data <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
`ifdef DMA_BURST_EN
                        r_addr     <= r_src + STEP;
                        r_drv_data <= 1'b0;
                        r_rd       <= 1'b1;
                        r_state    <= S_READ;
`else
                        r_dma_req  <= 1'b1;
                        r_state    <= S_REQ;
`endif
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus is driven only while this master both owns it and is in an access state.
    assign w_drv      = r_drv & r_dma_req;
    assign w_drv_data = w_drv & r_drv_data;

    assign addr_bus      = w_drv      ? r_addr : 'z;
    assign data_bus      = w_drv_data ? r_buf  : 'z;
    assign wr_bus        = w_drv      ? r_wr   : 1'bz;
    assign rd_bus        = w_drv      ? r_rd   : 1'bz;
    assign data_mask_bus = w_drv      ? 4'hF   : 4'bzzzz;

    assign ctl.dma_req = r_dma_req;
    assign ctl.busy    = r_busy;
    assign ctl.done    = r_done;
endmodule
